// File: rtl/csa_operand_recover.sv
// csa_operand_recover: bit-serial recovery of B = {cout,S} - A - cin, LSB first, with range check.
// Optional CSA_RECOVER_SAT_EN forces B to 0 whenever err is set.
module csa_operand_recover (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [1:0] cin,
   input  logic [3:0] S,
   input  logic [1:0] cout,
   output logic       busy,
   output logic       done,
   output logic [3:0] B,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
   state_t     state_q;
   logic [5:0] t_q, x_q, r_q, r_d;
   logic [2:0] cnt_q;
   logic       bw_q, bw_d, d_bit, busy_q, done_q, err_q, err_d;
   logic [3:0] b_q, b_d;
   always_comb begin
      d_bit = t_q[cnt_q] ^ x_q[cnt_q] ^ bw_q;
      bw_d  = (~t_q[cnt_q] & (x_q[cnt_q] | bw_q)) | (x_q[cnt_q] & bw_q);
      r_d   = {d_bit, r_q[5:1]};
      err_d = bw_d | (r_d[5:4] != 2'b00);
`ifdef CSA_RECOVER_SAT_EN
      b_d   = err_d ? 4'h0 : r_d[3:0];
`else
      b_d   = r_d[3:0];
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         x_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         bw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         b_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               t_q     <= {cout, S};
               x_q     <= {2'b00, A} + {4'b0000, cin};
               r_q     <= '0;
               bw_q    <= 1'b0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= SUB;
            end
            SUB: begin
               r_q   <= r_d;
               bw_q  <= bw_d;
               cnt_q <= cnt_q + 3'd1;
               // last bit: publish the result on the same edge the final borrow is known
               if (cnt_q == 3'd5) begin
                  b_q     <= b_d;
                  err_q   <= err_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign B    = b_q;
   assign err  = err_q;
endmodule
